// File: rtl/irq_ctrl.sv
// Six-source interrupt controller: edge-latched pending, mask + global enable, held request with ack/eret handshake.
// Latency: sampled edge -> PEND after 1 edge, int_req after 2 edges; Dout is combinational from Addr.
// No backpressure: int_req holds until int_ack or a software cancel. Build option IRQ_LEVEL_EN selects level-sensitive PEND.
module irq_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   input  logic [5:0]  hw_int,
   input  logic        int_ack,
   input  logic        eret,
   output logic        int_req,
   output logic [2:0]  int_id
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SVC = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [5:0]  pend_q, pend_d;
   logic [5:0]  im_q, im_d;
   logic        ie_q, ie_d;
   logic        insvc_q, insvc_d;
   logic        int_req_q, int_req_d;
   logic [2:0]  int_id_q, int_id_d;

   logic        ctrl_wr;
   logic [5:0]  elig;
   logic        any_elig;
   logic [2:0]  sel_id;
   logic [7:0]  pend_ext;
   logic        req_cancel;

   // Only the register index and the defined data bits are decoded.
   logic        unused_bits;
   assign unused_bits = &{1'b0, Addr[31:4], Din[31:9], Din[7:6]};

   assign ctrl_wr = WE && (Addr[3:2] == 2'd0);

`ifdef IRQ_LEVEL_EN
   // Level mode: PEND is hw_int delayed one cycle; W1C and the edge detector are absent.
   always_comb begin
      pend_d = hw_int;
   end
`else
   logic [5:0]  prev_q, prev_d;
   logic        pend_wr;
   logic [5:0]  w1c;
   assign pend_wr = WE && (Addr[3:2] == 2'd1);
   assign w1c     = pend_wr ? Din[5:0] : 6'b0;

   // Edge mode: rising edges set PEND and win over a same-cycle W1C clear.
   always_comb begin
      prev_d = hw_int;
      pend_d = (pend_q & ~w1c) | (hw_int & ~prev_q);
   end

   // Previous-sample register for the edge detector.
   always_ff @(posedge clk) begin
      if (!reset) prev_q <= 6'b0;
      else        prev_q <= prev_d;
   end
`endif

   // CTRL register update: mask and global enable.
   always_comb begin
      im_d = im_q;
      ie_d = ie_q;
      if (ctrl_wr) begin
         im_d = Din[5:0];
         ie_d = Din[8];
      end
   end

   // Eligible sources and lowest-index priority select.
   always_comb begin
      elig     = pend_q & im_q & {6{ie_q & ~insvc_q}};
      any_elig = |elig;
      sel_id   = 3'd7;
      for (int i = 5; i >= 0; i--) begin
         if (elig[i]) sel_id = 3'(i);
      end
   end

   // A pending request is withdrawn if software disables IE or clears the selected PEND bit.
   assign pend_ext   = {2'b00, pend_q};
   assign req_cancel = !ie_q || !pend_ext[int_id_q];

   // State and register flops, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         pend_q    <= 6'b0;
         im_q      <= 6'b0;
         ie_q      <= 1'b0;
         insvc_q   <= 1'b0;
         int_req_q <= 1'b0;
         int_id_q  <= 3'd7;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         im_q      <= im_d;
         ie_q      <= ie_d;
         insvc_q   <= insvc_d;
         int_req_q <= int_req_d;
         int_id_q  <= int_id_d;
      end
   end

   // Next-state logic; an ack in REQ takes precedence over a simultaneous cancel.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_elig) state_d = REQ;
         REQ:     if (int_ack) state_d = SVC;
                  else if (req_cancel) state_d = IDLE;
         SVC:     if (eret) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs and in-service flag, updated on state transitions.
   always_comb begin
      int_req_d = int_req_q;
      int_id_d  = int_id_q;
      insvc_d   = insvc_q;
      case (state_q)
         IDLE: begin
            if (any_elig) begin
               int_req_d = 1'b1;
               int_id_d  = sel_id;
            end
         end
         REQ: begin
            if (int_ack) begin
               int_req_d = 1'b0;
               insvc_d   = 1'b1;
            end else if (req_cancel) begin
               int_req_d = 1'b0;
               int_id_d  = 3'd7;
            end
         end
         SVC: begin
            if (eret) begin
               insvc_d  = 1'b0;
               int_id_d = 3'd7;
            end
         end
         default: begin
            int_req_d = 1'b0;
            int_id_d  = 3'd7;
            insvc_d   = 1'b0;
         end
      endcase
   end

   // Combinational register read mux.
   always_comb begin
      Dout = 32'h0;
      case (Addr[3:2])
         2'd0:    Dout = {23'b0, ie_q, 2'b0, im_q};
         2'd1:    Dout = {26'b0, pend_q};
         2'd2:    Dout = {insvc_q, 28'b0, int_id_q};
         default: Dout = 32'h0;
      endcase
   end

   assign int_req = int_req_q;
   assign int_id  = int_id_q;

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller sitting directly downstream of the timer/counter devices and upstream of the CPU's exception logic. It samples six device interrupt lines, including the timer IRQ, latches rising edges into a pending register and applies a mask plus a global enable. It then raises a single held interrupt request that the CPU acknowledges and retires with `eret`. Its registers are word-mapped on the same device bus as the timers.

## Interface
- No parameters; six sources fixed.
- `clk` in 1: system clock, all state on rising edge.
- `reset` in 1: synchronous, active-low; `reset == 0` at a rising edge clears all state.
- `Addr` in [31:2]: word address; only `Addr[3:2]` decoded.
- `WE` in 1: register write strobe.
- `Din` in 32: write data.
- `Dout` out 32: combinational read data for `Addr[3:2]`.
- `hw_int` in 6: device interrupt lines; bit 0 is the highest priority, and bit 0 carries the timer IRQ.
- `int_ack` in 1: CPU took the interrupt exception this cycle.
- `eret` in 1: CPU retired the handler this cycle.
- `int_req` out 1: registered interrupt request to the CPU.
- `int_id` out 3: index of the source being requested or serviced; 7 when there is none.

## Operation
- Register map by `Addr[3:2]`:
  - 0 CTRL, read/write: bits [5:0] are the mask `IM`, bit 8 is the global enable `IE`, all other bits read 0.
  - 1 PEND: bits [5:0] read as pending; writing 1 to a bit clears it (W1C).
  - 2 STAT, read-only: bits [2:0] are `int_id`, bit 31 is in-service.
  - 3 reads 0.
  - Writes to 2 and 3 are ignored.
- Edge capture:
  - `hw_int` is registered into `prev`.
  - A bit is a rising edge when `hw_int & ~prev`.
  - A rising edge sets the matching PEND bit.
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- Eligible sources are `PEND & IM`, gated by `IE` and not in-service.
- Selected source: the lowest-index eligible bit.
- State machine:
  - **IDLE**: `int_req = 0`. If any source is eligible, register its index into `int_id`, set `int_req = 1`, and go to REQ.
  - **REQ**: `int_req` held at 1 and `int_id` frozen even if new edges arrive. On `int_ack`: `int_req <= 0`, in-service set, go to SVC. If software clears `IE` or the selected PEND bit before the ack, drop `int_req` and return to IDLE.
  - **SVC**: no new request is issued. The handler clears PEND by W1C. On `eret`: in-service cleared, `int_id <= 7`, go to IDLE.
- `int_ack` outside REQ and `eret` outside SVC are ignored.
- If `int_ack` and `eret` arrive together, only the one legal in the current state acts.
- Reset values:
  - `int_req` = 0, `int_id` = 7.
  - PEND, `IM`, `IE`, `prev`, in-service all 0.
  - State is IDLE.
- Reset asserted in any state returns to IDLE on that edge; any in-flight request is dropped.

## Timing
- Edge on `hw_int[k]` sampled at edge N: PEND[k] = 1 after edge N.
- If eligible in IDLE, `int_req = 1` after edge N+1. Total latency from sampled edge to request is 2 cycles.
- `int_ack` at edge M: `int_req = 0` after M.
- `eret` at edge E: state is IDLE after E. A still-pending eligible source re-requests after E+1.
- `Dout` reflects register contents in the same cycle.
- A write at edge W is visible on `Dout` after W.
- A level held high produces exactly one edge; re-arming requires a low cycle.

## Configuration
- `IRQ_LEVEL_EN`:
  - When defined, PEND bits are level-sensitive: PEND mirrors `hw_int` registered by one cycle, W1C writes have no effect, and the edge detector is removed. Request latency stays 2 cycles. The timer's level IRQ stays pending until the timer itself is serviced.
  - When undefined, edge-latched behaviour as above.

## Test plan
- Reset with `reset = 0`: `int_req = 0`, `int_id = 7`, CTRL, PEND and STAT all read 0x0.
- Write CTRL = 0x101 and pulse `hw_int[0]` for 1 cycle:
  - PEND reads 0x1 one cycle later.
  - `int_req = 1` and `int_id = 0` two cycles after the edge.
  - `int_ack` drops `int_req`; STAT reads 0x80000000.
- CTRL = 0x13F with `hw_int = 6'b100100` rising together: `int_id = 2`. After W1C of PEND = 0x4 and `eret`, `int_id = 5` is requested 2 cycles later.
- Mask test with CTRL = 0x1FE and `hw_int[0]` edge: PEND = 0x1 and `int_req` stays 0. Writing CTRL = 0x1FF raises `int_req` 1 cycle later.
- Same-cycle W1C PEND = 0x8 and a new edge on `hw_int[3]`: PEND[3] stays 1.
- Reset pulse while in REQ: `int_req = 0` and `int_id = 7` the next cycle. With `IRQ_LEVEL_EN`, a W1C does not clear a held `hw_int[1]`.
